instruction_cache_dm: RTL and testbench
=======================================

Name: instruction_cache_dm

Overview:
Direct-mapped, read-only instruction cache between the fetch stage and a line-oriented backing memory port. It is the next generation of the team's static ROM instruction store: tag/valid arrays, a line refill FSM with a ready/valid memory handshake, and a flush input for self-modifying or reloaded code. One fetch per cycle on hits. A blocking miss is serviced in multi-beat bursts.

Parameters:
LINE_COUNT, 16, number of cache lines (power of two, >=2)
WORDS_PER_LINE, 4, words per line and beats per refill (power of two, >=2)
WORD_BITS, 32, instruction word width (multiple of 8)
ADDR_BITS, 32, byte-address width
Derived: OFF_B=$clog2(WORD_BITS/8), WRD_B=$clog2(WORDS_PER_LINE), IDX_B=$clog2(LINE_COUNT), TAG_B=ADDR_BITS-IDX_B-WRD_B-OFF_B

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  invalidate all lines (one-cycle pulse or level)
req_valid  in  1  fetch request
req_addr  in  ADDR_BITS  byte address; low OFF_B bits ignored
req_ready  out  1  request accepted when req_valid&&req_ready
rsp_valid  out  1  one-cycle pulse, rsp_data valid; no backpressure
rsp_data  out  WORD_BITS  fetched instruction word
mem_req_valid  out  1  line refill request
mem_req_addr  out  ADDR_BITS  line-aligned byte address (low WRD_B+OFF_B bits zero)
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  refill beat valid
mem_rsp_data  in  WORD_BITS  refill beat, word 0 first, ascending

Behaviour:
- Address split, MSB to LSB: tag | index | word | offset.
- Reset (async assert, sync release): state=READY, all valid bits=0, req_ready=1, rsp_valid=0, rsp_data=0, mem_req_valid=0, beat counter=0, flush_pending=0. Data and tag arrays are not reset.
- FSM states: READY, MEM_REQ, REFILL, RESPOND.
- READY: req_ready=1 unless flush or flush_pending is set.
  - On an accepted request, the tag and valid bit at index are compared combinationally.
  - Hit: rsp_valid=1 with the word on the next cycle (1-cycle latency). Stay in READY. Back-to-back hits give one response per cycle.
  - Miss: latch the address and go to MEM_REQ. No response is issued for the missed request until RESPOND.
- MEM_REQ: mem_req_valid=1 and mem_req_addr are held stable until mem_req_ready. On the handshake, go to REFILL with counter=0. req_ready=0.
- REFILL: each mem_rsp_valid writes data[index][counter] and increments the counter. On beat WORDS_PER_LINE-1: write the tag, set valid, go to RESPOND.
  - The requested word is taken from the stored beat; no critical-word-first.
  - Beats arriving in other states are ignored.
- RESPOND: rsp_valid=1 with the requested word for one cycle, then READY. Miss latency = handshake + WORDS_PER_LINE beats + 1 cycle.
- flush:
  - Sampled every cycle; sets flush_pending.
  - In READY with flush or flush_pending, all valid bits are cleared at the clock edge. flush_pending is cleared and no request is accepted that cycle.
  - During MEM_REQ/REFILL/RESPOND, the flush stays pending. The refill completes and its response is delivered, then all lines, including the new one, are invalidated on the first READY cycle.
- Simultaneous flush and hit in READY: flush wins and req_ready=0. A response to a hit accepted in the previous cycle is still delivered.
- Refill overwrites the line unconditionally (conflict eviction); no replacement policy.
- Reset mid-refill aborts the refill. The line stays invalid and no rsp_valid is produced. Stale mem_rsp beats after reset are ignored.
- Memory must not send beats before the request handshake.

Test Plan:
- Cold miss: reset, req 0x40, memory returns 0xA0..0xA3 after a 2-cycle ready delay -> mem_req_addr=0x40, 4 beats written, rsp_valid one cycle after the last beat with rsp_data=0xA0.
- Hit streaming: after the cold miss, reqs 0x44, 0x48, 0x4C on consecutive cycles -> rsp 0xA1, 0xA2, 0xA3 on consecutive cycles, mem_req_valid stays 0.
- Conflict: req 0x140 (index 4, tag 1) -> refill with mem_req_addr=0x140 and data 0xB0..0xB3. Then req 0x40 -> miss again, refill re-issued at 0x40.
- Flush: fill lines 0x00 and 0x40, pulse flush -> req_ready=0 that cycle. Next req 0x00 -> miss with mem_req_valid=1.
- Flush during REFILL after beat 1: the remaining beats complete and rsp is delivered. The following req to the same address -> miss.
- Reset at REFILL beat 2: outputs return to reset values immediately, a late mem_rsp_valid is ignored, and req 0x40 -> new miss at mem_req_addr 0x40.

Source files
------------

// File: rtl/instruction_cache_dm.sv
// instruction_cache_dm: direct-mapped read-only instruction cache with burst line refill and flush
module instruction_cache_dm #(
  parameter int LINE_COUNT     = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 32,
  parameter int ADDR_BITS      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [WORD_BITS-1:0] rsp_data,
  output logic                 mem_req_valid,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [WORD_BITS-1:0] mem_rsp_data
);
  localparam int OFF_B = $clog2(WORD_BITS / 8);
  localparam int WRD_B = $clog2(WORDS_PER_LINE);
  localparam int IDX_B = $clog2(LINE_COUNT);
  localparam int LO    = WRD_B + OFF_B;
  localparam int TAG_B = ADDR_BITS - IDX_B - LO;
  typedef enum logic [1:0] {READY, MEM_REQ, REFILL, RESPOND} state_t;
  state_t state;
  logic [WORD_BITS-1:0] data_mem [LINE_COUNT][WORDS_PER_LINE];
  logic [TAG_B-1:0]     tag_mem  [LINE_COUNT];
  logic [LINE_COUNT-1:0] valid;
  logic [ADDR_BITS-1:0]  miss_addr;
  logic [WRD_B-1:0]      cnt;
  logic                  flush_pending;
  logic [TAG_B-1:0]      req_tag, miss_tag;
  logic [IDX_B-1:0]      req_idx, miss_idx;
  logic [WRD_B-1:0]      req_wrd, miss_wrd;
  logic                  hit, accept, beat, last;
  assign req_tag  = req_addr[ADDR_BITS-1:LO+IDX_B];
  assign req_idx  = req_addr[LO+IDX_B-1:LO];
  assign req_wrd  = req_addr[LO-1:OFF_B];
  assign miss_tag = miss_addr[ADDR_BITS-1:LO+IDX_B];
  assign miss_idx = miss_addr[LO+IDX_B-1:LO];
  assign miss_wrd = miss_addr[LO-1:OFF_B];
  assign req_ready     = state == READY && !flush && !flush_pending;
  assign accept        = req_valid && req_ready;
  assign hit           = valid[req_idx] && tag_mem[req_idx] == req_tag;
  assign beat          = state == REFILL && mem_rsp_valid;
  assign last          = cnt == WRD_B'(WORDS_PER_LINE - 1);
  assign mem_req_valid = state == MEM_REQ;
  assign mem_req_addr  = {miss_addr[ADDR_BITS-1:LO], {LO{1'b0}}};
  // Storage arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (beat) begin
      data_mem[miss_idx][cnt] <= mem_rsp_data;
      if (last) tag_mem[miss_idx] <= miss_tag;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= READY;
      valid         <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      miss_addr     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state != READY && flush) flush_pending <= 1'b1;
      case (state)
        READY:
          if (flush || flush_pending) begin
            valid         <= '0;
            flush_pending <= 1'b0;
          end else if (accept) begin
            if (hit) begin
              rsp_valid <= 1'b1;
              rsp_data  <= data_mem[req_idx][req_wrd];
            end else begin
              miss_addr <= req_addr;
              state     <= MEM_REQ;
            end
          end
        MEM_REQ:
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= REFILL;
          end
        REFILL:
          if (mem_rsp_valid) begin
            cnt <= cnt + 1'b1;
            // The final beat is still in flight, so forward it if it is the requested word.
            if (last) begin
              valid[miss_idx] <= 1'b1;
              rsp_valid       <= 1'b1;
              rsp_data        <= miss_wrd == cnt ? mem_rsp_data : data_mem[miss_idx][miss_wrd];
              state           <= RESPOND;
            end
          end
        default: state <= READY;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_cache_dm.sv
// tb_instruction_cache_dm: directed vectors plus hand sequences for flush and reset corner cases
module tb_instruction_cache_dm;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, rsp_valid, mem_req_valid;
  logic [31:0] rsp_data, mem_req_addr;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  int checks = 0, fails = 0;

  instruction_cache_dm dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] base;
    int          dly;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Line contents are base+word; a miss is served by the bench acting as memory.
  task automatic fetch(input logic [31:0] a, input bit miss, input logic [31:0] base, input int dly);
    logic [31:0] exp;
    exp = base + 32'(a[3:2]);
    req_valid = 1'b1;
    req_addr  = a;
    #1 chk("req_ready", 32'(req_ready), 1);
    cyc;
    req_valid = 1'b0;
    if (!miss) begin
      chk("hit_rsp_valid", 32'(rsp_valid), 1);
      chk("hit_rsp_data", rsp_data, exp);
      chk("hit_no_mem_req", 32'(mem_req_valid), 0);
    end else begin
      chk("miss_no_rsp", 32'(rsp_valid), 0);
      chk("mem_req_valid", 32'(mem_req_valid), 1);
      chk("mem_req_addr", mem_req_addr, {a[31:4], 4'h0});
      repeat (dly) cyc;
      chk("mem_req_held", 32'(mem_req_valid), 1);
      chk("mem_req_addr_held", mem_req_addr, {a[31:4], 4'h0});
      chk("stall_ready", 32'(req_ready), 0);
      mem_req_ready = 1'b1;
      cyc;
      mem_req_ready = 1'b0;
      chk("mem_req_dropped", 32'(mem_req_valid), 0);
      for (int b = 0; b < 4; b++) begin
        chk("no_early_rsp", 32'(rsp_valid), 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = base + 32'(b);
        cyc;
      end
      mem_rsp_valid = 1'b0;
      chk("miss_rsp_valid", 32'(rsp_valid), 1);
      chk("miss_rsp_data", rsp_data, exp);
      cyc;
      chk("rsp_one_cycle", 32'(rsp_valid), 0);
    end
  endtask

  initial begin
    vec_t vecs[$];
    vecs = '{
      '{32'h40,  1, 32'hA0, 2},
      '{32'h44,  0, 32'hA0, 0},
      '{32'h48,  0, 32'hA0, 0},
      '{32'h4C,  0, 32'hA0, 0},
      '{32'h140, 1, 32'hB0, 0},
      '{32'h148, 0, 32'hB0, 0},
      '{32'h44,  1, 32'hA0, 1},
      '{32'h00,  1, 32'hC0, 0},
      '{32'h0C,  0, 32'hC0, 0},
      '{32'h48,  0, 32'hA0, 0}
    };
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].miss, vecs[i].base, vecs[i].dly);

    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h00;
    #1 chk("flush_ready", 32'(req_ready), 0);
    cyc;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_no_rsp", 32'(rsp_valid), 0);
    chk("flush_no_mem_req", 32'(mem_req_valid), 0);
    fetch(32'h00, 1, 32'hD0, 0);
    fetch(32'h04, 0, 32'hD0, 0);

    req_valid = 1'b1;
    req_addr  = 32'h08;
    cyc;
    flush    = 1'b1;
    req_addr = 32'h0C;
    #1 chk("flush_hit_ready", 32'(req_ready), 0);
    chk("prev_hit_valid", 32'(rsp_valid), 1);
    chk("prev_hit_data", rsp_data, 32'hD2);
    cyc;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_hit_no_rsp", 32'(rsp_valid), 0);
    chk("flush_hit_no_mem", 32'(mem_req_valid), 0);
    fetch(32'h40, 1, 32'hA0, 0);

    req_valid = 1'b1;
    req_addr  = 32'h80;
    cyc;
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    cyc;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hE0 + 32'(b);
      flush         = b == 1;
      cyc;
    end
    flush         = 1'b0;
    mem_rsp_valid = 1'b0;
    chk("flush_refill_rsp_valid", 32'(rsp_valid), 1);
    chk("flush_refill_rsp_data", rsp_data, 32'hE0);
    #1 chk("respond_ready", 32'(req_ready), 0);
    cyc;
    #1 chk("pending_flush_ready", 32'(req_ready), 0);
    cyc;
    fetch(32'h80, 1, 32'hF0, 0);

    req_valid = 1'b1;
    req_addr  = 32'h40;
    cyc;
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    cyc;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h90 + 32'(b);
      cyc;
    end
    mem_rsp_data = 32'h92;
    #2 rst_n = 1'b0;
    #1 chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_mem_req", 32'(mem_req_valid), 0);
    @(negedge clk);
    rst_n        = 1'b1;
    mem_rsp_data = 32'h93;
    cyc;
    mem_rsp_valid = 1'b0;
    chk("stale_beat_rsp", 32'(rsp_valid), 0);
    chk("stale_beat_mem_req", 32'(mem_req_valid), 0);
    fetch(32'h40, 1, 32'hA0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
